operand_decode_stage: RTL and testbench
=======================================

# operand_decode_stage

Parametrised register-read decode stage for the pipelined processor. It extracts the source and destination register specifiers from each instruction and selects rd or rt as the second source by opcode. It tracks outstanding register writes in a scoreboard, stalls the front end on RAW/WAW hazards, and hands decoded operands to the read stage through a one-entry valid/ready pipeline register.

## Interface
- `INSTR_W`, 32: instruction width.
- `OPC_W`, 5: opcode width; opcode = instruction[INSTR_W-1 -: OPC_W].
- `REG_W`, 5: register specifier width. Field positions: rd = [INSTR_W-OPC_W-1 -: REG_W], rs = next REG_W bits down, rt = next REG_W bits down (defaults 26:22, 21:17, 16:12).
- `RD_SRC_MASK`, 32'h0000_00D4: bit k set means opcode k reads rd as source 2. Default set is opcodes 2, 4, 6, 7.
- `WRITES_MASK`, 32'h0000_0121: bit k set means opcode k writes rd. Default set is opcodes 0, 5, 8.
- `STALL_CNT_W`, 16: stall counter width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: instruction accepted this cycle when in_valid & in_ready.
- `instruction` in INSTR_W: instruction word.
- `out_valid` out 1: decoded entry present.
- `out_ready` in 1: consumer takes the entry when out_valid & out_ready.
- `out_opcode` out OPC_W: registered opcode.
- `reg_S1` out REG_W: registered rs.
- `reg_S2` out REG_W: registered rd if rd_rt, else rt.
- `reg_D` out REG_W: registered rd.
- `rd_rt` out 1: registered RD_SRC_MASK[opcode].
- `writes_rd` out 1: registered WRITES_MASK[opcode] & (rd != 0).
- `wb_valid` in 1: writeback retiring a register write.
- `wb_reg` in REG_W: register being written back.
- `flush` in 1: discard the entry in the output register.
- `hazard` out 1: combinational; in_valid & the offered instruction conflicts.
- `stall_count` out STALL_CNT_W: saturating count of hazard cycles.

## Operation
- Decode is combinational on `instruction`. The same fields are captured into the output register on accept.
- Scoreboard: `pending[2**REG_W]` flags; `pending[0]` is hardwired 0.
- Effective pending this cycle: pend_eff[r] = pending[r] & ~(wb_valid & wb_reg==r). Writeback bypasses the hazard check because the register file is write-through.
- hazard = in_valid & (pend_eff[rs] | pend_eff[src2] | (writes & pend_eff[rd])). The last term is the WAW check. Register 0 never hazards.
- in_ready = reset & ~flush & ~hazard_core & (~out_valid | out_ready). Here hazard_core is the same conflict term as `hazard`, evaluated without the in_valid gate.
- On accept: load the output register and set out_valid=1. If writes_rd, set pending[rd].
- On consume without accept: out_valid=0.
- wb_valid clears pending[wb_reg]. If the same cycle also sets that register on accept, the set wins.
- flush: out_valid=0. If the flushed entry had writes_rd, clear pending[reg_D]; this rollback is applied before the wb clear and the accept set. No accept occurs in a flush cycle.
- stall_count increments each cycle `hazard`=1 and saturates at all-ones.

## Timing
- Reset (reset==0 at the clock edge) clears:
  - out_valid=0 and all registered outputs=0.
  - pending all 0.
  - stall_count=0.
- While reset is low, in_ready=0. Reset mid-operation drops any held entry without a flush.
- Latency: accept at edge N gives out_valid=1 with fields valid after edge N. Throughput is 1 per cycle while out_ready=1 and there is no hazard.
- The output register holds stable while out_valid & ~out_ready.
- A hazard caused by the previous accept stalls until the matching wb_valid. The dependent instruction is accepted in the same cycle as that wb_valid, through the bypass.
- `hazard` and `in_ready` are combinational from in_valid, instruction, wb_*, flush, out_ready, and state.

## Test plan
- Reset, then send opcode 00010 with rd=3, rs=1, rt=9 → next cycle: reg_S1=1, reg_S2=3, reg_D=3, rd_rt=1, writes_rd=0.
- Send opcode 00000 with rd=4, rs=2, rt=5, then opcode 00000 with rs=4 → the second instruction gets hazard=1 and in_ready=0. stall_count counts 3 over 3 cycles. Drive wb_valid with wb_reg=4 → accepted that same cycle, and pending[4] stays clear.
- Opcode 00000 with rd=0 → writes_rd=0, and a follow-up instruction reading r0 never stalls.
- Hold out_ready=0 with the entry at rd=6 and apply flush → out_valid=0 and pending[6]=0; an instruction reading r6 is then accepted immediately.
- Same-cycle wb_valid with wb_reg=7 and accept of an instruction writing rd=7 → pending[7]=1 afterwards.
- Assert reset mid-stall with pending[4]=1 → after reset, pending is clear, out_valid=0, stall_count=0, and in_ready=1.

Source files
------------

// File: rtl/operand_decode_stage.sv
// Register-read decode stage: field extraction, write scoreboard with RAW/WAW
// stall, and a one-entry valid/ready output register toward the read stage.
module operand_decode_stage #(
  parameter int                   INSTR_W     = 32,
  parameter int                   OPC_W       = 5,
  parameter int                   REG_W       = 5,
  parameter logic [2**OPC_W-1:0]  RD_SRC_MASK = 32'h0000_00D4,
  parameter logic [2**OPC_W-1:0]  WRITES_MASK = 32'h0000_0121,
  parameter int                   STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPC_W-1:0]       out_opcode,
  output logic [REG_W-1:0]       reg_S1,
  output logic [REG_W-1:0]       reg_S2,
  output logic [REG_W-1:0]       reg_D,
  output logic                   rd_rt,
  output logic                   writes_rd,
  input  logic                   wb_valid,
  input  logic [REG_W-1:0]       wb_reg,
  input  logic                   flush,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int NREG   = 2**REG_W;
  localparam int RD_MSB = INSTR_W - OPC_W - 1;
  localparam int RS_MSB = RD_MSB - REG_W;
  localparam int RT_MSB = RS_MSB - REG_W;

  logic [OPC_W-1:0] dec_opc;
  logic [REG_W-1:0] dec_rd, dec_rs, dec_rt, dec_s2;
  logic             dec_rd_rt, dec_writes;
  logic             unused_low_bits;

  assign dec_opc    = instruction[INSTR_W-1 -: OPC_W];
  assign dec_rd     = instruction[RD_MSB -: REG_W];
  assign dec_rs     = instruction[RS_MSB -: REG_W];
  assign dec_rt     = instruction[RT_MSB -: REG_W];
  assign dec_rd_rt  = RD_SRC_MASK[dec_opc];
  assign dec_s2     = dec_rd_rt ? dec_rd : dec_rt;
  assign dec_writes = WRITES_MASK[dec_opc] & (dec_rd != '0);
  assign unused_low_bits = ^instruction[RT_MSB-REG_W:0];

  logic [NREG-1:0] pending, pending_nxt, wb_mask, pend_eff;
  logic            hazard_core, accept;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_reg] = 1'b1;
  end

  // A retiring write is visible the same cycle because the register file writes through.
  assign pend_eff    = pending & ~wb_mask;
  assign hazard_core = pend_eff[dec_rs] | pend_eff[dec_s2] | (dec_writes & pend_eff[dec_rd]);
  assign hazard      = in_valid & hazard_core;
  assign in_ready    = reset & ~flush & ~hazard_core & (~out_valid | out_ready);
  assign accept      = in_valid & in_ready;

  // Order matters: flush rollback, then writeback clear, then the accept set wins.
  always_comb begin
    pending_nxt = pending;
    if (flush && out_valid && writes_rd) pending_nxt[reg_D] = 1'b0;
    pending_nxt = pending_nxt & ~wb_mask;
    if (accept && dec_writes) pending_nxt[dec_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the scoreboard is only NREG flag bits, so it is reset like ordinary state.
      pending     <= '0;
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      reg_S1      <= '0;
      reg_S2      <= '0;
      reg_D       <= '0;
      rd_rt       <= 1'b0;
      writes_rd   <= 1'b0;
      stall_count <= '0;
    end else begin
      pending <= pending_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_opcode <= dec_opc;
        reg_S1     <= dec_rs;
        reg_S2     <= dec_s2;
        reg_D      <= dec_rd;
        rd_rt      <= dec_rd_rt;
        writes_rd  <= dec_writes;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (hazard && (stall_count != '1)) stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_decode_stage.sv
// Self-checking bench for operand_decode_stage: decode table, scoreboard of
// expected output entries, and directed hazard/flush/reset sequences.
module tb_operand_decode_stage;

  localparam logic [31:0] RD_SRC_M = 32'h0000_00D4;
  localparam logic [31:0] WRITE_M  = 32'h0000_0121;

  typedef struct {
    logic [4:0] opc, s1, s2, d;
    logic       rd_rt, wr;
  } exp_t;

  typedef struct {
    logic [4:0] opc, rd, rs, rt;
    logic [4:0] s2;
    logic       rd_rt, wr;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction;
  logic [4:0]  out_opcode, reg_S1, reg_S2, reg_D, wb_reg;
  logic        rd_rt, writes_rd, wb_valid, flush, hazard;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t none;

  operand_decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .reg_S1(reg_S1), .reg_S2(reg_S2), .reg_D(reg_D),
    .rd_rt(rd_rt), .writes_rd(writes_rd), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .hazard(hazard), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] opc, rd, rs, rt);
    return {opc, rd, rs, rt, 12'h000};
  endfunction

  function automatic exp_t mk(input logic [4:0] opc, rd, rs, rt);
    exp_t e;
    e.opc   = opc;
    e.s1    = rs;
    e.rd_rt = RD_SRC_M[opc];
    e.s2    = e.rd_rt ? rd : rt;
    e.d     = rd;
    e.wr    = WRITE_M[opc] && (rd != 5'd0);
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge; queue the expected entry if accepted.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] i, input logic ordy,
                       input logic wbv, input logic [4:0] wbr, input logic fl, input exp_t e);
    @(negedge clock);
    reset = rst; in_valid = v; instruction = i; out_ready = ordy;
    wb_valid = wbv; wb_reg = wbr; flush = fl;
    #1;
    if (v && in_ready) sb_q.push_back(e);
  endtask

  task automatic send(input logic [4:0] opc, rd, rs, rt, input logic ordy,
                      input logic wbv, input logic [4:0] wbr, input logic fl);
    cycle(1'b1, 1'b1, ins(opc, rd, rs, rt), ordy, wbv, wbr, fl, mk(opc, rd, rs, rt));
  endtask

  task automatic idle(input logic ordy, input logic wbv, input logic [4:0] wbr);
    cycle(1'b1, 1'b0, 32'h0, ordy, wbv, wbr, 1'b0, none);
  endtask

  // Output monitor: an entry leaves on consume or is discarded on flush.
  always @(negedge clock) begin
    #2;
    if (reset && out_valid && (flush || out_ready)) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (!flush)
          check("out_entry", {10'd0, out_opcode, reg_S1, reg_S2, reg_D, rd_rt, writes_rd},
                {10'd0, mon_e.opc, mon_e.s1, mon_e.s2, mon_e.d, mon_e.rd_rt, mon_e.wr});
      end
    end
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{5'd2,  5'd3,  5'd1,  5'd9,  5'd3,  1'b1, 1'b0};
    tbl[1] = '{5'd1,  5'd10, 5'd11, 5'd12, 5'd12, 1'b0, 1'b0};
    tbl[2] = '{5'd4,  5'd13, 5'd14, 5'd15, 5'd13, 1'b1, 1'b0};
    tbl[3] = '{5'd5,  5'd20, 5'd1,  5'd2,  5'd2,  1'b0, 1'b1};
    tbl[4] = '{5'd6,  5'd21, 5'd22, 5'd23, 5'd21, 1'b1, 1'b0};
    tbl[5] = '{5'd8,  5'd24, 5'd25, 5'd26, 5'd26, 1'b0, 1'b1};
    tbl[6] = '{5'd0,  5'd0,  5'd3,  5'd4,  5'd4,  1'b0, 1'b0};
    tbl[7] = '{5'd7,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b0};
    tbl[8] = '{5'd31, 5'd31, 5'd30, 5'd29, 5'd29, 1'b0, 1'b0};
    none = mk(5'd0, 5'd0, 5'd0, 5'd0);

    reset = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, none);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, none);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_stall", stall_count, 0);
    check("rst_reg_D", reg_D, 0);
    check("rst_pending", dut.pending, 0);

    // Decode table, back-to-back at full throughput
    foreach (tbl[k]) begin
      exp_t e;
      e = '{tbl[k].opc, tbl[k].rs, tbl[k].s2, tbl[k].rd, tbl[k].rd_rt, tbl[k].wr};
      cycle(1'b1, 1'b1, ins(tbl[k].opc, tbl[k].rd, tbl[k].rs, tbl[k].rt), 1'b1, 1'b0, 5'd0, 1'b0, e);
      check($sformatf("tbl%0d_in_ready", k), in_ready, 1);
      check($sformatf("tbl%0d_hazard", k), hazard, 0);
    end
    idle(1'b1, 1'b0, 5'd0);
    check("tbl_pending", dut.pending, 32'h0110_0000);
    idle(1'b1, 1'b1, 5'd20);
    idle(1'b1, 1'b1, 5'd24);
    idle(1'b1, 1'b0, 5'd0);
    check("tbl_pending_clear", dut.pending, 0);

    // RAW stall released by same-cycle writeback bypass
    send(5'd0, 5'd4, 5'd2, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      send(5'd0, 5'd1, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
      check($sformatf("raw_hazard%0d", c), hazard, 1);
      check($sformatf("raw_in_ready%0d", c), in_ready, 0);
    end
    send(5'd0, 5'd1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd4, 1'b0);
    check("raw_bypass_hazard", hazard, 0);
    check("raw_bypass_ready", in_ready, 1);
    check("raw_stall3", stall_count, 3);
    idle(1'b1, 1'b0, 5'd0);
    check("raw_pending", dut.pending, 32'h0000_0002);
    idle(1'b1, 1'b1, 5'd1);

    // WAW stall, in_valid gating of hazard
    send(5'd5, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    send(5'd8, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("waw_hazard", hazard, 1);
    cycle(1'b1, 1'b0, ins(5'd8, 5'd9, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0, none);
    check("waw_no_valid", hazard, 0);
    send(5'd8, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0);
    check("waw_bypass_ready", in_ready, 1);
    idle(1'b1, 1'b1, 5'd9);
    idle(1'b1, 1'b0, 5'd0);
    check("waw_pending_clear", dut.pending, 0);
    check("waw_stall4", stall_count, 4);

    // Hold under backpressure, then flush with pending rollback
    send(5'd0, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(1'b0, 1'b0, 5'd0);
    check("hold_valid", out_valid, 1);
    check("hold_pending6", dut.pending, 32'h0000_0040);
    idle(1'b0, 1'b0, 5'd0);
    check("hold_reg_D", reg_D, 6);
    send(5'd1, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    check("flush_in_ready", in_ready, 0);
    send(5'd1, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("flush_out_valid", out_valid, 0);
    check("flush_pending", dut.pending, 0);
    check("flush_then_ready", in_ready, 1);

    // Writeback and accept set of the same register: set wins
    send(5'd5, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    send(5'd8, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0);
    check("wbset_ready", in_ready, 1);
    idle(1'b1, 1'b0, 5'd0);
    check("wbset_pending7", dut.pending, 32'h0000_0080);
    idle(1'b1, 1'b1, 5'd7);

    // Reset in the middle of a stall with an entry held
    send(5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    send(5'd0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    send(5'd0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("mid_hazard", hazard, 1);
    cycle(1'b0, 1'b1, ins(5'd0, 5'd1, 5'd4, 5'd0), 1'b0, 1'b0, 5'd0, 1'b0, none);
    check("mid_rst_in_ready", in_ready, 0);
    sb_q.delete();
    send(5'd0, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_pending", dut.pending, 32'h0);
    check("post_rst_stall", stall_count, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Drain
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) idle(1'b1, 1'b0, 5'd0);
    idle(1'b1, 1'b0, 5'd0);
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
